dmem_arbiter: RTL

Shares the single-port data memory between the MIPS-32 core and a second master, a loader/debug port used for preloading and inspecting data memory. The block sits between the core's data-memory bus and the data memory.
- The core has fixed priority. A starvation counter guarantees the loader a slot after a bounded wait.
- The core is stalled in any cycle its access is denied.
- Loader transactions complete with a registered one-cycle acknowledge.

---
 rtl/dmem_arbiter_pkg.sv | 26 ++
 rtl/dmem_starve_counter.sv | 45 ++++
 rtl/dmem_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: grant owner codes, FSM states
// and the starvation counter width. Imported by the RTL and by benches.
package dmem_arbiter_pkg;

  // Owner codes reported on the owner port.
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CORE = 2'b01;
  localparam logic [1:0] OWN_LD   = 2'b10;

  // Starvation counter width; MAX_WAIT is limited to 1..15.
  localparam int unsigned CNT_W = 4;

  // Loader transaction FSM.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_e;

  // Owner code from the two mutually exclusive grant terms.
  function automatic logic [1:0] ownerEnc(input logic coreGrant, input logic ldGrant);
    if (ldGrant)        return OWN_LD;
    else if (coreGrant) return OWN_CORE;
    else                return OWN_NONE;
  endfunction

endpackage

// File: rtl/dmem_starve_counter.sv
// Saturating starvation counter for the loader port.
// Ports:
//   Clk, Reset : clock, async active-low reset
//   clr        : clear to zero (takes priority over inc)
//   inc        : increment, saturating at MAX_WAIT; neither clr nor inc holds
//   sat        : registered flag, count equals MAX_WAIT
module dmem_starve_counter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr,
  input  logic inc,
  output logic sat
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;

  // Next count: clear wins, increment stops at the ceiling.
  always_comb begin
    cntNext = cnt;
    if (clr) begin
      cntNext = '0;
    end else if (inc && (cnt != MAX_CNT)) begin
      cntNext = cnt + CNT_W'(1);
    end
  end

  // sat is registered from the next count so it is valid in the same cycle as cnt.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      cnt <= cntNext;
      sat <= (cntNext == MAX_CNT);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the MIPS-32 core (fixed priority) and a
// loader/debug port. The loader is force-granted after MAX_WAIT consecutive
// denied cycles; each loader transfer is acknowledged one cycle after grant.
// Ports:
//   Clk, Reset            : clock, async active-low reset
//   core_*                : core data bus; core_Stall flags a denied access
//   ld_*                  : loader request/ack handshake, registered read data
//   mem_*                 : single-port data memory interface
//   owner                 : current-cycle grant (OWN_NONE/OWN_CORE/OWN_LD)
// Grant, mux, stall and owner are combinational; ld_ack/ld_rdata are registered.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              core_MemRead,
  input  logic              core_MemWrite,
  input  logic [ADDR_W-1:0] core_Address,
  input  logic [DATA_W-1:0] core_WriteData,
  output logic [DATA_W-1:0] core_ReadData,
  output logic              core_Stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  input  logic [DATA_W-1:0] mem_ReadData,
  output logic [ADDR_W-1:0] mem_Address,
  output logic [DATA_W-1:0] mem_WriteData,
  output logic              mem_MemWrite,
  output logic              mem_MemRead,
  output logic [1:0]        owner
);

  state_e state;
  state_e stateNext;

  logic coreReq;
  logic ldElig;
  logic ldGrant;
  logic coreGrant;
  logic starveSat;

  // Loader waits out the ACK cycle, so back-to-back transfers are 2 cycles apart.
  assign coreReq = core_MemRead | core_MemWrite;
  assign ldElig  = ld_req & (state == S_IDLE);

  dmem_starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (ldGrant | ~ld_req),
    .inc   (ldElig & ~ldGrant),
    .sat   (starveSat)
  );

  // Grant, memory mux, stall and next state.
  always_comb begin
    ldGrant       = ldElig & (starveSat | ~coreReq);
    coreGrant     = coreReq & ~ldGrant;
    core_Stall    = coreReq & ~coreGrant;
    owner         = ownerEnc(coreGrant, ldGrant);
    mem_Address   = '0;
    mem_WriteData = '0;
    mem_MemWrite  = 1'b0;
    mem_MemRead   = 1'b0;
    stateNext     = S_IDLE;

    if (ldGrant) begin
      mem_Address   = ld_addr;
      mem_WriteData = ld_wdata;
      mem_MemWrite  = ld_we;
      mem_MemRead   = ~ld_we;
    end else if (coreGrant) begin
      mem_Address   = core_Address;
      mem_WriteData = core_WriteData;
      mem_MemWrite  = core_MemWrite;
      // Simultaneous read and write from the core is treated as a write.
      mem_MemRead   = core_MemRead & ~core_MemWrite;
    end

    case (state)
      S_IDLE:  stateNext = ldGrant ? S_ACK : S_IDLE;
      S_ACK:   stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  // Core read data is a straight pass-through; the core ignores it when stalled.
  assign core_ReadData = mem_ReadData;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= S_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Acknowledge and capture loader read data one cycle after the grant.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ld_ack   <= 1'b0;
      ld_rdata <= '0;
    end else begin
      ld_ack <= ldGrant;
      if (ldGrant && !ld_we) begin
        ld_rdata <= mem_ReadData;
      end
    end
  end

endmodule
